// File: rtl/fcvt_pkg.sv
// Shared types for the float<->int conversion scheduler.
// Tags are carried alongside these entries so their width can follow the instantiating module.
package fcvt_pkg;

  typedef enum logic {
    CVT_F2I = 1'b0,
    CVT_I2F = 1'b1
  } cvt_op_t;

  localparam int SRC_W = 1;

  typedef struct packed {
    logic             valid;
    cvt_op_t          op;
    logic [SRC_W-1:0] src;
    logic [31:0]      data;
  } s1_entry_t;

  typedef struct packed {
    logic             valid;
    logic             exc;
    logic [SRC_W-1:0] src;
    logic [31:0]      data;
  } s2_entry_t;

endpackage

// File: rtl/fcvt_conv.sv
// Combinational float<->int converters: zero latency, no flow control.
// f2i rounds half away from zero and saturates on overflow; i2f rounds to nearest even.
module fcvt_f2i (
  input  logic [31:0] a,
  output logic [31:0] res,
  output logic        exc
);

  logic        sign;
  logic [7:0]  ex;
  logic [23:0] sig;
  logic [24:0] q;
  logic [31:0] mag;

  always_comb begin
    sign = a[31];
    ex   = a[30:23];
    sig  = {1'b1, a[22:0]};
    q    = '0;
    mag  = '0;
    if (ex >= 8'd158) begin
      mag = '0;
    end else if (ex >= 8'd150) begin
      mag = {8'd0, sig} << (ex - 8'd150);
    end else if (ex >= 8'd126) begin
      // q[0] is the first fraction bit, which decides the half-away rounding
      q   = {sig, 1'b0} >> (8'd150 - ex);
      mag = {8'd0, q[24:1]} + {31'd0, q[0]};
    end
    exc = (ex >= 8'd158) && (a != 32'hCF00_0000);
    if (ex >= 8'd158) res = sign ? 32'h8000_0000 : 32'h7FFF_FFFF;
    else              res = sign ? (~mag + 32'd1) : mag;
  end

endmodule

module fcvt_i2f (
  input  logic [31:0] a,
  output logic [31:0] res
);

  logic        sign;
  logic [31:0] mag;
  logic [31:0] norm;
  logic [4:0]  msb;
  logic        inc;
  logic [24:0] rnd;
  logic [7:0]  ex;

  always_comb begin
    sign = a[31];
    mag  = sign ? (~a + 32'd1) : a;
    msb  = '0;
    for (int i = 0; i < 32; i++) begin
      if (mag[i]) msb = i[4:0];
    end
    norm = mag << (5'd31 - msb);
    inc  = norm[7] && ((|norm[6:0]) || norm[8]);
    // a carry out of the significand bumps the exponent and leaves a zero mantissa
    rnd  = {1'b0, norm[31:8]} + {24'd0, inc};
    ex   = 8'd127 + {3'd0, msb} + {7'd0, rnd[24]};
    res  = (mag == '0) ? 32'd0 : {sign, ex, rnd[22:0]};
  end

endmodule

// File: rtl/fcvt_rr_pick.sv
// Two-way round-robin picker: combinational, zero latency, one-hot grant.
// Contended requests go to prio; the pointer register lives in the caller.
module fcvt_rr_pick (
  input  logic [1:0] valid,
  input  logic       prio,
  output logic [1:0] grant
);

  always_comb begin
    grant = valid;
    if (valid == 2'b11) grant = prio ? 2'b10 : 2'b01;
  end

endmodule

// File: rtl/fcvt_scheduler.sv
// Two-port round-robin scheduler onto one float<->int converter; fire-to-resp_valid latency 2 edges.
// S2 stalls while its owner withholds resp_ready, blocking both ports; req_ready drops once S1 and S2 are full.
module fcvt_scheduler
  import fcvt_pkg::*;
#(
  parameter int TAG_W = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [1:0]            req_valid,
  output logic [1:0]            req_ready,
  input  logic [1:0]            req_op,
  input  logic [1:0][31:0]      req_data,
  input  logic [1:0][TAG_W-1:0] req_tag,
  output logic [1:0]            resp_valid,
  input  logic [1:0]            resp_ready,
  output logic [31:0]           resp_data,
  output logic                  resp_exception,
  output logic [TAG_W-1:0]      resp_tag
);

  s1_entry_t        s1;
  s2_entry_t        s2;
  logic [TAG_W-1:0] s1_tag;
  logic [TAG_W-1:0] s2_tag;
  logic             prio;

  logic [1:0]       grant;
  logic             sel;
  logic             resp_fire;
  logic             adv2;
  logic             s1_accept;
  logic             req_fire;
  logic [31:0]      f2i_res;
  logic             f2i_exc;
  logic [31:0]      i2f_res;

  fcvt_rr_pick u_pick (
    .valid (req_valid),
    .prio  (prio),
    .grant (grant)
  );

  fcvt_f2i u_f2i (
    .a   (s1.data),
    .res (f2i_res),
    .exc (f2i_exc)
  );

  fcvt_i2f u_i2f (
    .a   (s1.data),
    .res (i2f_res)
  );

  assign sel       = grant[1];
  assign resp_fire = s2.valid && resp_ready[s2.src];
  assign adv2      = !s2.valid || resp_fire;
  assign s1_accept = !s1.valid || adv2;
  assign req_ready = rst ? 2'b00 : (grant & {2{s1_accept}});
  assign req_fire  = |(req_valid & req_ready);

  assign resp_valid     = (s2.valid && !rst) ? (s2.src[0] ? 2'b10 : 2'b01) : 2'b00;
  assign resp_data      = s2.data;
  assign resp_exception = s2.exc;
  assign resp_tag       = s2_tag;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1     <= '0;
      s2     <= '0;
      s1_tag <= '0;
      s2_tag <= '0;
      prio   <= 1'b0;
    end else begin
      if (s1.valid && adv2) begin
        s2.valid <= 1'b1;
        s2.exc   <= (s1.op == CVT_F2I) && f2i_exc;
        s2.src   <= s1.src;
        s2.data  <= (s1.op == CVT_I2F) ? i2f_res : f2i_res;
        s2_tag   <= s1_tag;
      end else if (resp_fire) begin
        s2.valid <= 1'b0;
      end

      if (req_fire) begin
        s1.valid <= 1'b1;
        s1.op    <= cvt_op_t'(req_op[sel]);
        s1.src   <= SRC_W'(sel);
        s1.data  <= req_data[sel];
        s1_tag   <= req_tag[sel];
        prio     <= ~sel;
      end else if (s1.valid && adv2) begin
        s1.valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_fcvt_scheduler.sv
// Directed bench for fcvt_scheduler: single conversions, round-robin, backpressure, reset flush.
// Inputs change on the falling edge; outputs are sampled 1ns later, well away from the rising edge.
module tb_fcvt_scheduler;

  localparam int TAG_W = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [1:0]            req_valid;
  logic [1:0]            req_ready;
  logic [1:0]            req_op;
  logic [1:0][31:0]      req_data;
  logic [1:0][TAG_W-1:0] req_tag;
  logic [1:0]            resp_valid;
  logic [1:0]            resp_ready;
  logic [31:0]           resp_data;
  logic                  resp_exception;
  logic [TAG_W-1:0]      resp_tag;

  int n_cmp = 0;
  int n_err = 0;

  // backpressure scenario, one entry per cycle
  int          bp_vld [10] = '{1, 1, 1, 1, 1, 1, 1, 0, 0, 0};
  int          bp_tag [10] = '{0, 1, 2, 2, 2, 2, 3, 0, 0, 0};
  int          bp_rr  [10] = '{0, 0, 0, 0, 0, 1, 1, 1, 1, 1};
  int          bp_rdy [10] = '{1, 1, 0, 0, 0, 1, 1, 0, 0, 0};
  int          bp_rv  [10] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 0};
  int          bp_otag[10] = '{0, 0, 0, 0, 0, 0, 1, 2, 3, 0};
  logic [31:0] i2f_small[4] = '{32'h0000_0000, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000};

  always #5 clk = ~clk;

  fcvt_scheduler #(.TAG_W(TAG_W)) dut (
    .clk            (clk),
    .rst            (rst),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_op         (req_op),
    .req_data       (req_data),
    .req_tag        (req_tag),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_data      (resp_data),
    .resp_exception (resp_exception),
    .resp_tag       (resp_tag)
  );

  task automatic check_eq(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // one isolated conversion: fire, S1, S2 visible, drained
  task automatic send_one(input string name, input int p, input logic op, input logic [31:0] dat,
                          input logic [3:0] tag, input bit chk_dat, input logic [31:0] exp_dat,
                          input logic exp_exc);
    logic [1:0] onehot;
    onehot       = (p == 1) ? 2'b10 : 2'b01;
    req_op[p]    = op;
    req_data[p]  = dat;
    req_tag[p]   = tag;
    req_valid    = onehot;
    resp_ready   = 2'b11;
    #1;
    check_eq({name, "_rdy"}, 32'(req_ready), 32'(onehot));
    @(negedge clk);
    req_valid = 2'b00;
    #1;
    check_eq({name, "_s1"}, 32'(resp_valid), 32'd0);
    @(negedge clk);
    #1;
    check_eq({name, "_vld"}, 32'(resp_valid), 32'(onehot));
    if (chk_dat) check_eq({name, "_dat"}, resp_data, exp_dat);
    check_eq({name, "_exc"}, 32'(resp_exception), 32'(exp_exc));
    check_eq({name, "_tag"}, 32'(resp_tag), 32'(tag));
    @(negedge clk);
    #1;
    check_eq({name, "_done"}, 32'(resp_valid), 32'd0);
  endtask

  initial begin
    rst        = 1'b1;
    req_valid  = 2'b00;
    resp_ready = 2'b00;
    req_op     = 2'b00;
    req_data   = '0;
    req_tag    = '0;

    // reset state
    @(negedge clk);
    #1;
    check_eq("rst_req_ready", 32'(req_ready), 32'd0);
    check_eq("rst_resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst_resp_data", resp_data, 32'd0);
    check_eq("rst_resp_exc", 32'(resp_exception), 32'd0);
    check_eq("rst_resp_tag", 32'(resp_tag), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // single conversions and boundaries
    send_one("f2i_1p5",   0, 1'b0, 32'h3FC0_0000, 4'h1, 1, 32'h0000_0002, 1'b0);
    send_one("f2i_m2p5",  0, 1'b0, 32'hC020_0000, 4'h2, 1, 32'hFFFF_FFFD, 1'b0);
    send_one("f2i_2p31",  0, 1'b0, 32'h4F00_0000, 4'h3, 0, 32'h0,         1'b1);
    send_one("f2i_m2p31", 1, 1'b0, 32'hCF00_0000, 4'h4, 1, 32'h8000_0000, 1'b0);
    send_one("f2i_nan",   1, 1'b0, 32'h7FC0_0000, 4'h5, 0, 32'h0,         1'b1);
    send_one("f2i_half",  0, 1'b0, 32'h3F00_0000, 4'h6, 1, 32'h0000_0001, 1'b0);
    send_one("f2i_sub_h", 1, 1'b0, 32'h3EFF_FFFF, 4'h7, 1, 32'h0000_0000, 1'b0);
    send_one("i2f_min",   1, 1'b1, 32'h8000_0000, 4'h8, 1, 32'hCF00_0000, 1'b0);
    send_one("i2f_max",   0, 1'b1, 32'h7FFF_FFFF, 4'h9, 1, 32'h4F00_0000, 1'b0);

    // both ports contending every cycle from reset
    do_reset();
    req_op      = 2'b11;
    req_data[0] = 32'd7;
    req_data[1] = 32'hFFFF_FFFF;
    req_tag[0]  = 4'h3;
    req_tag[1]  = 4'hA;
    resp_ready  = 2'b11;
    req_valid   = 2'b11;
    for (int k = 0; k < 10; k++) begin
      #1;
      check_eq("rr_grant", 32'(req_ready), (k % 2 == 0) ? 32'd1 : 32'd2);
      if (k >= 2) begin
        check_eq("rr_resp_vld", 32'(resp_valid), (k % 2 == 0) ? 32'd1 : 32'd2);
        check_eq("rr_resp_dat", resp_data, (k % 2 == 0) ? 32'h40E0_0000 : 32'hBF80_0000);
        check_eq("rr_resp_tag", 32'(resp_tag), (k % 2 == 0) ? 32'h3 : 32'hA);
      end
      @(negedge clk);
    end
    req_valid = 2'b00;

    // backpressure on port 0, then drain with same-edge refill
    do_reset();
    req_op = 2'b11;
    for (int k = 0; k < 10; k++) begin
      req_valid   = {1'b0, bp_vld[k][0]};
      req_tag[0]  = 4'(bp_tag[k]);
      req_data[0] = 32'(bp_tag[k]);
      resp_ready  = {1'b1, bp_rr[k][0]};
      #1;
      check_eq("bp_req_ready", 32'(req_ready), 32'(bp_rdy[k]));
      check_eq("bp_resp_vld", 32'(resp_valid), 32'(bp_rv[k]));
      if (bp_rv[k] != 0) begin
        check_eq("bp_resp_tag", 32'(resp_tag), 32'(bp_otag[k]));
        check_eq("bp_resp_dat", resp_data, i2f_small[bp_otag[k]]);
      end
      @(negedge clk);
    end

    // reset with both stages occupied; prio points at port 1 beforehand
    do_reset();
    req_op      = 2'b11;
    req_data[0] = 32'd1;
    req_tag[0]  = 4'h5;
    req_valid   = 2'b01;
    @(negedge clk);
    req_tag[0]  = 4'h6;
    @(negedge clk);
    rst       = 1'b1;
    req_valid = 2'b11;
    #1;
    check_eq("flush_rst_rdy", 32'(req_ready), 32'd0);
    check_eq("flush_rst_vld", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst        = 1'b0;
    req_valid  = 2'b00;
    resp_ready = 2'b11;
    for (int k = 0; k < 3; k++) begin
      #1;
      check_eq("flush_no_resp", 32'(resp_valid), 32'd0);
      @(negedge clk);
    end
    req_valid = 2'b11;
    #1;
    check_eq("flush_first_grant", 32'(req_ready), 32'd1);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fcvt_scheduler.md
# fcvt_scheduler

Shared conversion scheduler for the FPU: arbitrates two requesters (integer-pipe port 0, FPU-pipe port 1) onto a single float↔int conversion datapath. Uses round-robin arbitration, a two-stage registered pipeline around the combinational converters, and valid/ready handshakes on both request and response sides. Responses are steered back to the originating requester with its tag.

## Interface
- `TAG_W`, default 4: width of the requester-supplied tag returned with each result.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `req_valid` in [1:0]: per-requester request valid.
- `req_ready` out [1:0]: per-requester request accept.
- `req_op` in [1:0]: per-requester op. 0 = float→int (fcvt.w.s), 1 = int→float (fcvt.s.w).
- `req_data` in [1:0][31:0]: operand.
- `req_tag` in [1:0][TAG_W-1:0]: opaque tag.
- `resp_valid` out [1:0]: result valid, asserted only toward the originating requester.
- `resp_ready` in [1:0]: requester accepts result.
- `resp_data` out [31:0]: converted value, shared by both requesters.
- `resp_exception` out 1: overflow/NaN flag. Always 0 for int→float.
- `resp_tag` out [TAG_W-1:0]: tag of the current result.

## Operation
- Request fire on port i: `req_valid[i] && req_ready[i]` at a rising edge. Response fire: `resp_valid[i] && resp_ready[i]`.
- Pipeline stages:
  - S1 holds op, operand, src id, tag and a valid bit.
  - The converters are combinational from S1.
  - S2 holds result, exception, src id, tag and a valid bit.
- Advance rules:
  - `adv2 = !s2_valid || resp_fire`.
  - S1→S2 transfer happens when `s1_valid && adv2`.
  - S1 accepts a new request when `!s1_valid || adv2`.
- Arbitration:
  - Single priority pointer `prio` (0/1).
  - When both ports are valid, grant goes to `prio`. Otherwise grant goes to whichever port is valid.
  - `req_ready[i] = grant[i] && s1_accept`. At most one bit of `req_ready` is high.
  - On a request fire, `prio` becomes the non-granted port. With no fire, `prio` holds.
- `req_ready` may depend on both `req_valid` bits. Requesters must not make `req_valid` depend on `req_ready`. A requester holds valid and payload stable until fire.
- `resp_valid[s2_src] = s2_valid`, and the other bit is 0. `resp_data`, `resp_exception` and `resp_tag` are meaningful only while some `resp_valid` is high.
- Head-of-line blocking is intended: a requester that withholds `resp_ready` stalls both ports.
- Float→int semantics:
  - Round half away from zero on magnitude, then two's-complement negate if the sign is set.
  - Exception when the biased exponent is ≥ 158 (this includes NaN/Inf), except for exactly −2^31 (0xCF000000).
- Int→float: round to nearest, exception 0.

## Timing
- Latency: a request fired at edge t loads S1 at t and S2 at t+1. `resp_valid` is high from after t+1 until the response fires.
- Throughput: 1 conversion/cycle when `resp_ready` stays high.
- Simultaneous S2 drain and S1 refill in the same edge is required, with no bubble.
- Full: with S1 and S2 both valid and no response fire, `req_ready` = 0 and both stages hold.
- Reset:
  - `s1_valid` = `s2_valid` = 0, `prio` = 0.
  - `resp_valid` = 0 and `req_ready` = 0 while `rst` is high.
  - `resp_data`, `resp_exception`, `resp_tag` reset to 0.
- Reset mid-operation discards in-flight conversions silently; no response is ever issued for them.
- `resp_*` are driven from registers only. No combinational path from `resp_ready` to `resp_valid`/`resp_data`.

## Structure
- Package `fcvt_pkg`:
  - `cvt_op_t` enum (`CVT_F2I` = 0, `CVT_I2F` = 1).
  - `SRC_W` = 1.
  - Packed structs `s1_entry_t` and `s2_entry_t` (parameterised on tag via `TAG_W` at use site).
- Sub-module `fcvt_rr_pick`: 2-way round-robin picker (inputs valid[1:0], prio, outputs one-hot grant). It is combinational; the pointer register lives in the scheduler.
- The existing combinational float→int and int→float converters are instantiated once each, and S1 `op` selects the result mux into S2.

## Test plan
- Port 0 sends F2I 0x3FC00000 (1.5), then −2.5 (0xC0200000), `resp_ready` = 1 → `resp_valid[0]` 2 cycles after each fire; data 0x00000002 then 0xFFFFFFFD; exception 0.
- Boundary: F2I 0x4F000000 → exception 1. F2I 0xCF000000 → data 0x80000000, exception 0. F2I 0x7FC00000 (NaN) → exception 1.
- Both ports valid every cycle from reset, I2F with port 0 = 7 and port 1 = −1 → grants alternate 0,1,0,…; results 0x40E00000 to port 0 and 0xBF800000 to port 1; tags preserved.
- Backpressure: `resp_ready[0]` = 0 for 3 cycles with continuous requests → `req_ready` = 0 once S1 and S2 are full. On release, the results drain in order with none lost or duplicated.
- Drain/refill: both stages full, `resp_ready` = 1 with a new request pending → S2 output and S1 load occur on the same edge with no bubble.
- Assert `rst` for 1 cycle with both stages valid → no `resp_valid` afterwards for the discarded ops; the first post-reset grant goes to port 0.
